// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, types and bit-permutation helpers
// Purpose: holds every fixed DES table (IP, FP, E, P, PC1, PC2, S1..S8),
// the per-round rotate schedule and the shared typedefs.
// Bit numbering: tables use FIPS numbering (bit 1 = MSB); in an N-bit
// vector FIPS bit n lives at index N-n.
package des_pkg;

    typedef logic [63:0] block_t;
    typedef logic [27:0] half_key_t;
    typedef logic [47:0] subkey_t;

    typedef enum logic [1:0] {KS_IDLE, KS_GEN, KS_READY} ks_state_t;

    // Bit r-1 set means round r rotates by one; all other rounds rotate by two.
    localparam logic [15:0] ROT_ONE = 16'h8103;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Indexed [box][row*16 + col].
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic block_t perm_ip(input block_t x);
        block_t r = '0;
        for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
        return r;
    endfunction

    function automatic block_t perm_fp(input block_t x);
        block_t r = '0;
        for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
        return r;
    endfunction

    function automatic logic [47:0] expand_e(input logic [31:0] x);
        logic [47:0] r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[5'(32 - E_TBL[i])];
        return r;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[5'(31 - i)] = x[5'(32 - P_TBL[i])];
        return r;
    endfunction

    function automatic logic [55:0] perm_pc1(input block_t k);
        logic [55:0] r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
        return r;
    endfunction

    function automatic subkey_t perm_pc2(input logic [55:0] cd);
        subkey_t r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        return r;
    endfunction

    // Six input bits b1..b6: row = b1b6, column = b2..b5.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] six);
        logic [5:0] idx;
        idx = {six[5], six[0], six[4:1]};
        return 4'(SBOX[box][idx]);
    endfunction

    function automatic half_key_t rotl_half(input half_key_t h, input logic by_one);
        return by_one ? {h[26:0], h[27]} : {h[25:0], h[27:26]};
    endfunction

endpackage

// File: rtl/des_round.sv
// rtl/des_round.sv - one combinational DES round (f-function plus half swap)
// Ports:
//   lr_in   in  64  {L, R} state entering the round
//   subkey  in  48  round subkey
//   lr_out  out 64  {R, L ^ f(R, subkey)}
module des_round
    import des_pkg::*;
(
    input  logic [63:0] lr_in,
    input  logic [47:0] subkey,
    output logic [63:0] lr_out
);

    logic [31:0] l_half;
    logic [31:0] r_half;
    logic [47:0] mixed;
    logic [31:0] sbox_out;
    logic [31:0] f_out;

    always_comb begin
        l_half   = lr_in[63:32];
        r_half   = lr_in[31:0];
        mixed    = expand_e(r_half) ^ subkey;
        sbox_out = '0;
        for (int b = 0; b < 8; b++) begin
            sbox_out[5'(31 - 4 * b) -: 4] = sbox_lookup(b, mixed[6'(47 - 6 * b) -: 6]);
        end
        f_out  = perm_p(sbox_out);
        lr_out = {r_half, l_half ^ f_out};
    end

endmodule

// File: rtl/des_engine.sv
// rtl/des_engine.sv - DES engine: iterative key schedule, 16-stage round pipeline
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   encrypt             mode latched on a key load (1 = encrypt)
//   keys_64_in          64-bit key, FIPS bit 1 = MSB
//   change_keys_en      load key/mode and restart the key schedule
//   subkeys_16_valid    all 16 subkeys ready for the latched key/mode
//   data_input_en       block present on data_64_in
//   data_64_in          input block
//   data_64_out         result block, held while data_output_valid is low
//   data_output_valid   one-cycle pulse per accepted block
module des_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        encrypt,
    input  logic [63:0] keys_64_in,
    input  logic        change_keys_en,
    output logic        subkeys_16_valid,
    input  logic        data_input_en,
    input  logic [63:0] data_64_in,
    output logic [63:0] data_64_out,
    output logic        data_output_valid
);

    ks_state_t   state_q, state_d;
    logic [4:0]  round_q, round_d;
    half_key_t   c_q, c_d, d_q, d_d;
    logic        enc_q, enc_d;
    subkey_t     subkey_q [16];
    subkey_t     subkey_d [16];

    block_t      stage_q [17];
    block_t      stage_d [17];
    block_t      round_out [16];
    logic [16:0] vld_q, vld_d;
    block_t      out_q, out_d;
    logic        out_vld_q, out_vld_d;

    logic        accept;
    logic        rot_one;
    half_key_t   c_rot, d_rot;
    subkey_t     k_new;
    logic [3:0]  slot;

    // Key schedule: C/D rotate once per GEN cycle; decrypt mode stores the
    // subkeys in reverse so the datapath always walks slots 1..16.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        c_d      = c_q;
        d_d      = d_q;
        enc_d    = enc_q;
        subkey_d = subkey_q;
        rot_one  = ROT_ONE[4'(round_q - 5'd1)];
        c_rot    = rotl_half(c_q, rot_one);
        d_rot    = rotl_half(d_q, rot_one);
        k_new    = perm_pc2({c_rot, d_rot});
        slot     = enc_q ? 4'(round_q - 5'd1) : 4'(5'd16 - round_q);

        if (change_keys_en) begin
            {c_d, d_d} = perm_pc1(keys_64_in);
            enc_d      = encrypt;
            state_d    = KS_GEN;
            round_d    = 5'd1;
        end else begin
            case (state_q)
                KS_GEN: begin
                    c_d            = c_rot;
                    d_d            = d_rot;
                    subkey_d[slot] = k_new;
                    if (round_q == 5'd16) state_d = KS_READY;
                    else                  round_d = round_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_round
        des_round u_round (
            .lr_in  (stage_q[g]),
            .subkey (subkey_q[g]),
            .lr_out (round_out[g])
        );
    end

    // Stage 0 holds IP(block); stage i holds the state after round i.
    // A key load kills every in-flight valid bit, including the output one.
    always_comb begin
        accept     = data_input_en && (state_q == KS_READY) && !change_keys_en;
        stage_d[0] = accept ? perm_ip(data_64_in) : stage_q[0];
        for (int i = 1; i < 17; i++) stage_d[i] = round_out[i - 1];
        vld_d      = change_keys_en ? '0 : {vld_q[15:0], accept};
        out_d      = out_q;
        out_vld_d  = 1'b0;
        if (vld_q[16] && !change_keys_en) begin
            out_d     = perm_fp({stage_q[16][31:0], stage_q[16][63:32]});
            out_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KS_IDLE;
            round_q   <= '0;
            c_q       <= '0;
            d_q       <= '0;
            enc_q     <= 1'b0;
            subkey_q  <= '{default: '0};
            stage_q   <= '{default: '0};
            vld_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            c_q       <= c_d;
            d_q       <= d_d;
            enc_q     <= enc_d;
            subkey_q  <= subkey_d;
            stage_q   <= stage_d;
            vld_q     <= vld_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign subkeys_16_valid  = (state_q == KS_READY);
    assign data_64_out       = out_q;
    assign data_output_valid = out_vld_q;

endmodule

// File: tb/tb_des_engine.sv
// tb/tb_des_engine.sv - directed self-checking bench for des_engine
module tb_des_engine;

    logic        clk;
    logic        rst_n;
    logic        encrypt;
    logic [63:0] keys_64_in;
    logic        change_keys_en;
    logic        subkeys_16_valid;
    logic        data_input_en;
    logic [63:0] data_64_in;
    logic [63:0] data_64_out;
    logic        data_output_valid;

    int          total = 0;
    int          bad   = 0;
    logic        seen;
    logic [63:0] ct_b;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT_B  = 64'h0123456789AB0000;

    des_engine dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .encrypt           (encrypt),
        .keys_64_in        (keys_64_in),
        .change_keys_en    (change_keys_en),
        .subkeys_16_valid  (subkeys_16_valid),
        .data_input_en     (data_input_en),
        .data_64_in        (data_64_in),
        .data_64_out       (data_64_out),
        .data_output_valid (data_output_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (data_output_valid === 1'b1) seen = 1'b1;
        end
    endtask

    // Load edge, then valid must still be low after 15 more edges and high after 16.
    task automatic load_key(input string tag, input logic [63:0] k, input logic enc);
        keys_64_in     = k;
        encrypt        = enc;
        change_keys_en = 1'b1;
        step();
        change_keys_en = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check({tag, "_skv_low"}, {63'b0, subkeys_16_valid}, 64'd0);
        step();
        check({tag, "_skv_high"}, {63'b0, subkeys_16_valid}, 64'd1);
    endtask

    task automatic send(input logic [63:0] d);
        data_input_en = 1'b1;
        data_64_in    = d;
        step();
        data_input_en = 1'b0;
    endtask

    // Single block: output pulse exactly after edge N+17, then held.
    task automatic one_block(input string tag, input logic [63:0] d, input logic [63:0] exp);
        send(d);
        for (int i = 0; i < 16; i++) step();
        check({tag, "_early_vld"}, {63'b0, data_output_valid}, 64'd0);
        step();
        check({tag, "_vld"}, {63'b0, data_output_valid}, 64'd1);
        check({tag, "_data"}, data_64_out, exp);
        step();
        check({tag, "_vld_drop"}, {63'b0, data_output_valid}, 64'd0);
        check({tag, "_hold"}, data_64_out, exp);
    endtask

    initial begin
        rst_n          = 1'b0;
        encrypt        = 1'b0;
        keys_64_in     = '0;
        change_keys_en = 1'b0;
        data_input_en  = 1'b0;
        data_64_in     = '0;
        seen           = 1'b0;
        ct_b           = '0;
        step();
        step();
        check("rst_skv", {63'b0, subkeys_16_valid}, 64'd0);
        check("rst_vld", {63'b0, data_output_valid}, 64'd0);
        check("rst_data", data_64_out, 64'd0);
        rst_n = 1'b1;
        step();

        // Encrypt key and subkey spot checks.
        load_key("ld_enc", KEY_A, 1'b1);
        check("k1_slot1", {16'b0, dut.subkey_q[0]}, 64'h00001B02EFFC7072);
        check("k16_slot16", {16'b0, dut.subkey_q[15]}, 64'h0000CB3D8B0E17F5);
        one_block("enc_a", PT_A, CT_A);

        // Back-to-back acceptance.
        send(PT_A);
        send(PT_B);
        for (int i = 0; i < 15; i++) step();
        check("b2b_early", {63'b0, data_output_valid}, 64'd0);
        step();
        check("b2b_vld0", {63'b0, data_output_valid}, 64'd1);
        check("b2b_data0", data_64_out, CT_A);
        step();
        check("b2b_vld1", {63'b0, data_output_valid}, 64'd1);
        ct_b = data_64_out;
        total++;
        assert (ct_b !== CT_A && ct_b !== PT_B) else begin
            bad++;
            $error("FAIL b2b_data1 observed=%h expected=distinct_ciphertext", ct_b);
        end
        step();
        check("b2b_vld_drop", {63'b0, data_output_valid}, 64'd0);

        // Key load held two edges; first edge coincides with a data request.
        seen           = 1'b0;
        keys_64_in     = KEY_A;
        encrypt        = 1'b0;
        change_keys_en = 1'b1;
        data_input_en  = 1'b1;
        data_64_in     = PT_A;
        step();
        step();
        change_keys_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (data_output_valid === 1'b1) seen = 1'b1;
        end
        data_input_en = 1'b0;
        step();
        check("restart_skv_low", {63'b0, subkeys_16_valid}, 64'd0);
        step();
        check("restart_skv_high", {63'b0, subkeys_16_valid}, 64'd1);
        check("dec_slot1_k16", {16'b0, dut.subkey_q[0]}, 64'h0000CB3D8B0E17F5);
        watch(20);
        check("ignored_inputs", {63'b0, seen}, 64'd0);

        // Decrypt both ciphertexts back to plaintext.
        one_block("dec_a", CT_A, PT_A);
        one_block("dec_b", ct_b, PT_B);

        // Further known-answer vectors.
        load_key("ld_k2", 64'h0E329232EA6D0D73, 1'b1);
        one_block("enc_k2", 64'h8787878787878787, 64'h0000000000000000);
        load_key("ld_k0", 64'h0000000000000000, 1'b1);
        one_block("enc_k0", 64'h0000000000000000, 64'h8CA64DE9C1B123A7);

        // Reload while blocks are in flight.
        load_key("ld_fl", KEY_A, 1'b1);
        seen = 1'b0;
        send(PT_A);
        send(PT_B);
        send(PT_A);
        watch(5);
        keys_64_in     = KEY_A;
        encrypt        = 1'b1;
        change_keys_en = 1'b1;
        step();
        change_keys_en = 1'b0;
        watch(40);
        check("flush_no_out", {63'b0, seen}, 64'd0);
        check("flush_hold", data_64_out, 64'h8CA64DE9C1B123A7);
        check("flush_skv", {63'b0, subkeys_16_valid}, 64'd1);

        // Asynchronous reset mid-operation.
        send(PT_A);
        send(PT_B);
        for (int i = 0; i < 16; i++) step();
        check("pre_rst_vld", {63'b0, data_output_valid}, 64'd1);
        check("pre_rst_data", data_64_out, CT_A);
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", {63'b0, data_output_valid}, 64'd0);
        check("async_rst_data", data_64_out, 64'd0);
        check("async_rst_skv", {63'b0, subkeys_16_valid}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        seen  = 1'b0;
        watch(30);
        check("post_rst_no_out", {63'b0, seen}, 64'd0);
        check("post_rst_skv", {63'b0, subkeys_16_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
